axis_fifo: RTL and testbench

Parametrised synchronous FIFO with AXI-Stream style valid/ready on both sides, carrying data plus a tlast marker. It is the successor to the plain wren/ren FIFO used in the UART path. All 2^AWIDTH entries are usable. It adds occupancy and almost-full/almost-empty thresholds, synchronous flush, and an optional store-and-forward packet mode. It sits between the UART byte engines and AXI-Stream producers/consumers.

---
 rtl/axis_fifo.sv | 100 ++++++++++
 tb/tb_axis_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO with tlast, occupancy/packet counters, flush and
// optional store-and-forward packet mode.
module axis_fifo #(
  parameter int AWIDTH      = 4,
  parameter int DWIDTH      = 8,
  parameter int AF_THRESH   = (1 << AWIDTH) - 2,
  parameter int AE_THRESH   = 1,
  parameter int PACKET_MODE = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [AWIDTH:0]   occupancy,
  output logic [AWIDTH:0]   pkt_count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_L = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_L   = (AWIDTH+1)'(AF_THRESH);
  localparam logic [AWIDTH:0] AE_L   = (AWIDTH+1)'(AE_THRESH);

  logic [DWIDTH:0]   mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   occ_q;
  logic [AWIDTH:0]   pkt_q;
  logic              ready_en;
  logic              wr;
  logic              rd;
  logic              wr_last;
  logic              rd_last;

  assign s_axis_tready = ready_en && (occ_q != FULL_L);
  assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

  // Packet mode holds the head back until a whole packet is stored, unless the
  // FIFO is full with no tlast, which would otherwise deadlock.
  always_comb begin
    m_axis_tvalid = (occ_q != '0);
    if (PACKET_MODE != 0)
      m_axis_tvalid = (occ_q != '0) && ((pkt_q != '0) || (occ_q == FULL_L));
  end

  assign wr      = s_axis_tvalid && s_axis_tready;
  assign rd      = m_axis_tvalid && m_axis_tready;
  assign wr_last = wr && s_axis_tlast;
  assign rd_last = rd && m_axis_tlast;

  assign occupancy    = occ_q;
  assign pkt_count    = pkt_q;
  assign almost_full  = (occ_q >= AF_L);
  assign almost_empty = (occ_q <= AE_L);

  always_ff @(posedge clk) begin
    if (wr && !flush)
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ_q  <= '0;
        pkt_q  <= '0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (rd) rd_ptr <= rd_ptr + 1'b1;
        case ({wr, rd})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
        case ({wr_last, rd_last})
          2'b10:   pkt_q <= pkt_q + 1'b1;
          2'b01:   pkt_q <= pkt_q - 1'b1;
          default: pkt_q <= pkt_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo: one cut-through instance (u0) and one
// store-and-forward instance (u1), default AWIDTH=4 / DWIDTH=8.
module tb_axis_fifo;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // cut-through instance
  logic       flush0 = 1'b0;
  logic [7:0] s0_data = '0;
  logic       s0_last = 1'b0, s0_valid = 1'b0, s0_ready;
  logic [7:0] m0_data;
  logic       m0_last, m0_valid, m0_ready = 1'b0;
  logic [4:0] occ0, pkt0;
  logic       af0, ae0;

  // packet-mode instance
  logic       flush1 = 1'b0;
  logic [7:0] s1_data = '0;
  logic       s1_last = 1'b0, s1_valid = 1'b0, s1_ready;
  logic [7:0] m1_data;
  logic       m1_last, m1_valid, m1_ready = 1'b0;
  logic [4:0] occ1, pkt1;
  logic       af1, ae1;

  axis_fifo #(.AWIDTH(4), .DWIDTH(8), .PACKET_MODE(0)) u0 (
    .clk(clk), .rstn(rstn), .flush(flush0),
    .s_axis_tdata(s0_data), .s_axis_tlast(s0_last), .s_axis_tvalid(s0_valid),
    .s_axis_tready(s0_ready),
    .m_axis_tdata(m0_data), .m_axis_tlast(m0_last), .m_axis_tvalid(m0_valid),
    .m_axis_tready(m0_ready),
    .occupancy(occ0), .pkt_count(pkt0), .almost_full(af0), .almost_empty(ae0)
  );

  axis_fifo #(.AWIDTH(4), .DWIDTH(8), .PACKET_MODE(1)) u1 (
    .clk(clk), .rstn(rstn), .flush(flush1),
    .s_axis_tdata(s1_data), .s_axis_tlast(s1_last), .s_axis_tvalid(s1_valid),
    .s_axis_tready(s1_ready),
    .m_axis_tdata(m1_data), .m_axis_tlast(m1_last), .m_axis_tvalid(m1_valid),
    .m_axis_tready(m1_ready),
    .occupancy(occ1), .pkt_count(pkt1), .almost_full(af1), .almost_empty(ae1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    tick();
    chk("rst_s0_ready", 32'(s0_ready), 0);
    chk("rst_m0_valid", 32'(m0_valid), 0);
    chk("rst_ae0", 32'(ae0), 1);
    chk("rst_af0", 32'(af0), 0);
    chk("rst_m1_valid", 32'(m1_valid), 0);
    tick();
    rstn = 1'b1;
    chk("post_rst_ready_low", 32'(s0_ready), 0);
    tick();
    chk("post_rst_ready_high", 32'(s0_ready), 1);
    chk("post_rst_occ", 32'(occ0), 0);
    chk("post_rst_valid", 32'(m0_valid), 0);
    chk("post_rst_ae", 32'(ae0), 1);

    // fill 16 beats with consumer stalled
    s0_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s0_data = 8'(i);
      tick();
      chk("fill_occ", 32'(occ0), 32'(i + 1));
      chk("fill_af", 32'(af0), 32'((i + 1) >= 14));
      chk("fill_valid", 32'(m0_valid), 1);
    end
    s0_valid = 1'b0;
    chk("full_ready", 32'(s0_ready), 0);
    tick();
    chk("full_hold_occ", 32'(occ0), 16);

    // drain in order
    m0_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(m0_valid), 1);
      chk("drain_data", 32'(m0_data), 32'(i));
      chk("drain_ae", 32'(ae0), 32'((16 - i) <= 1));
      tick();
      chk("drain_occ", 32'(occ0), 32'(15 - i));
    end
    chk("empty_valid", 32'(m0_valid), 0);
    chk("empty_ae", 32'(ae0), 1);

    // continuous streaming across pointer wrap
    s0_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s0_data = 8'(8'h40 + i);
      if (i > 0) begin
        chk("stream_valid", 32'(m0_valid), 1);
        chk("stream_data", 32'(m0_data), 32'(8'h40 + i - 1));
      end
      tick();
      chk("stream_occ", 32'(occ0), 1);
    end
    s0_valid = 1'b0;
    chk("stream_last_data", 32'(m0_data), 32'h67);
    tick();
    chk("stream_end_occ", 32'(occ0), 0);
    chk("stream_end_valid", 32'(m0_valid), 0);

    // flush at occupancy 5 with concurrent write and read
    m0_ready = 1'b0;
    s0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s0_data = 8'(8'h10 + i);
      s0_last = (i == 1);
      tick();
    end
    s0_last = 1'b0;
    chk("pre_flush_occ", 32'(occ0), 5);
    chk("pre_flush_pkt", 32'(pkt0), 1);
    s0_data  = 8'hEE;
    m0_ready = 1'b1;
    flush0   = 1'b1;
    tick();
    flush0   = 1'b0;
    s0_valid = 1'b0;
    m0_ready = 1'b0;
    chk("flush_occ", 32'(occ0), 0);
    chk("flush_pkt", 32'(pkt0), 0);
    chk("flush_valid", 32'(m0_valid), 0);
    chk("flush_ready", 32'(s0_ready), 1);
    s0_valid = 1'b1;
    s0_data  = 8'hA5;
    tick();
    s0_valid = 1'b0;
    chk("post_flush_valid", 32'(m0_valid), 1);
    chk("post_flush_data", 32'(m0_data), 32'hA5);
    chk("post_flush_occ", 32'(occ0), 1);
    m0_ready = 1'b1;
    tick();
    chk("post_flush_drained", 32'(occ0), 0);

    // packet mode: 3-beat packet
    s1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s1_data = 8'(8'h30 + i);
      s1_last = (i == 2);
      tick();
      chk("pkt_valid", 32'(m1_valid), 32'(i == 2));
      chk("pkt_count", 32'(pkt1), 32'(i == 2));
    end
    s1_valid = 1'b0;
    s1_last  = 1'b0;
    m1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pkt_drain_data", 32'(m1_data), 32'(8'h30 + i));
      chk("pkt_drain_last", 32'(m1_last), 32'(i == 2));
      tick();
    end
    m1_ready = 1'b0;
    chk("pkt_drained_count", 32'(pkt1), 0);
    chk("pkt_drained_occ", 32'(occ1), 0);
    chk("pkt_drained_valid", 32'(m1_valid), 0);

    // packet mode: 16 beats without tlast, full-escape
    s1_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s1_data = 8'(8'h60 + i);
      tick();
      chk("esc_valid", 32'(m1_valid), 32'(i == 15));
    end
    s1_valid = 1'b0;
    chk("esc_occ", 32'(occ1), 16);
    chk("esc_head", 32'(m1_data), 32'h60);
    m1_ready = 1'b1;
    tick();
    m1_ready = 1'b0;
    chk("esc_after_read_occ", 32'(occ1), 15);
    chk("esc_after_read_valid", 32'(m1_valid), 0);
    s1_valid = 1'b1;
    s1_data  = 8'h7F;
    s1_last  = 1'b1;
    tick();
    s1_valid = 1'b0;
    s1_last  = 1'b0;
    chk("esc_close_pkt", 32'(pkt1), 1);
    chk("esc_close_valid", 32'(m1_valid), 1);
    m1_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      chk("esc_drain_data", 32'(m1_data), (i == 16) ? 32'h7F : 32'(8'h60 + i));
      tick();
    end
    chk("esc_drain_occ", 32'(occ1), 0);
    chk("esc_drain_pkt", 32'(pkt1), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
